// File: rtl/z3_master_cycle_pkg.sv
// Shared definitions for the Zorro III bus-master cycle engine:
// the state encoding, the default timing parameters and the byte-lane decode.
package z3_master_cycle_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        GRANT   = 3'd2,
        ADDR    = 3'd3,
        DATA    = 3'd4,
        TERM    = 3'd5,
        RELEASE = 3'd6,
        ERROR   = 3'd7
    } z3_state_e;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;
    localparam int SYNC_STAGES_DEFAULT    = 2;
    localparam int TIMER_WIDTH            = 8;

    // Active-low data strobes for a transfer of size siz starting at byte a.
    // Lane k (0 = D31:24) drives strobe bit 3-k; a transfer that would run
    // past lane 3 is simply clipped there.
    function automatic logic [3:0] lane_strobes(input logic [1:0] siz, input logic [1:0] a);
        logic [2:0] n;
        logic [2:0] lo;
        logic [2:0] hi;
        logic [3:0] ds;
        n  = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
        lo = {1'b0, a};
        hi = lo + n;
        ds = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) >= lo) && (3'(k) < hi)) begin
                ds[3-k] = 1'b0;
            end
        end
        return ds;
    endfunction

endpackage

// File: rtl/z3_sync.sv
// Multi-stage synchronizer for an asynchronous Zorro input.
// It resets to the input's negated level so that a reset never looks like an
// assertion on the bus.
module z3_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw input through the flop chain, oldest sample at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            for (int i = STAGES - 1; i > 0; i--) begin
                chain_q[i] <= chain_q[i-1];
            end
            chain_q[0] <= d_i;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle engine that turns NCR-side transfers into
// Zorro full cycles: arbitration, strobe generation, termination and timeout.
// Every output comes straight from a flop; the next output values are decoded
// from the next state so they line up with the state they describe.
module z3_master_cycle
    import z3_master_cycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SBR,
    output logic       SBG,
    input  logic       S_AS_n,
    input  logic       S_READ,
    input  logic [1:0] S_SIZ,
    input  logic [1:0] S_A,
    output logic       S_STERM_n,
    output logic       S_BERR_n,
    output logic       Z_BR_n,
    input  logic       Z_BG_n,
    input  logic       Z_DTACK_n,
    input  logic       Z_BERR_n,
    output logic       Z_FCS_n,
    output logic [3:0] Z_DS_n,
    output logic       Z_DOE,
    output logic       Z_READ,
    output logic       MASTER
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

    logic bg_s;
    logic dtack_s;
    logic berr_s;

    z3_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bg (
        .clk (CLK),
        .rst (RESET),
        .d_i (Z_BG_n),
        .q_o (bg_s)
    );

    z3_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_dtack (
        .clk (CLK),
        .rst (RESET),
        .d_i (Z_DTACK_n),
        .q_o (dtack_s)
    );

    z3_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_berr (
        .clk (CLK),
        .rst (RESET),
        .d_i (Z_BERR_n),
        .q_o (berr_s)
    );

    z3_state_e              state_q, state_d;
    logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
    logic                   read_q, read_d;
    logic [3:0]             lanes_q, lanes_d;

    logic       sbg_q, sbg_d;
    logic       sterm_n_q, sterm_n_d;
    logic       berr_n_q, berr_n_d;
    logic       br_n_q, br_n_d;
    logic       fcs_n_q, fcs_n_d;
    logic [3:0] ds_n_q, ds_n_d;
    logic       doe_q, doe_d;
    logic       zread_q, zread_d;
    logic       master_q, master_d;

    logic       timeout;

    // Next state, timeout counter and transfer latches, then output decode of the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        read_d  = read_q;
        lanes_d = lanes_q;
        timeout = (cnt_q == TIMEOUT_LIMIT);

        case (state_q)
            IDLE: begin
                if (SBR) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!SBR) begin
                    state_d = IDLE;
                end else if (!bg_s) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d = '0;
                if (!S_AS_n) begin
                    state_d = ADDR;
                    read_d  = S_READ;
                    lanes_d = lane_strobes(S_SIZ, S_A);
                end else if (!SBR) begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                cnt_d = cnt_q + 1'b1;
                if (!berr_s || timeout) begin
                    state_d = ERROR;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (!berr_s) begin
                    state_d = ERROR;
                end else if (!dtack_s) begin
                    state_d = TERM;
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            TERM:    state_d = RELEASE;
            ERROR:   state_d = RELEASE;
            RELEASE: begin
                if (dtack_s) begin
                    state_d = GRANT;
                end
            end
            default: state_d = IDLE;
        endcase

        br_n_d    = 1'b1;
        sbg_d     = 1'b0;
        master_d  = 1'b0;
        fcs_n_d   = 1'b1;
        ds_n_d    = 4'hF;
        doe_d     = 1'b0;
        zread_d   = 1'b1;
        sterm_n_d = 1'b1;
        berr_n_d  = 1'b1;

        case (state_d)
            ARB: begin
                br_n_d = 1'b0;
            end
            GRANT: begin
                br_n_d   = 1'b0;
                sbg_d    = 1'b1;
                master_d = 1'b1;
            end
            ADDR, DATA, TERM, ERROR, RELEASE: begin
                br_n_d   = 1'b0;
                sbg_d    = 1'b1;
                master_d = 1'b1;
                zread_d  = read_d;
                fcs_n_d  = (state_d == RELEASE);
                if (state_d == DATA) begin
                    ds_n_d = lanes_d;
                    doe_d  = 1'b1;
                end
                if (state_d == TERM) begin
                    sterm_n_d = 1'b0;
                end
                if (state_d == ERROR) begin
                    berr_n_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // State, counter, latches and the registered bus outputs; reset forces the idle bus.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            read_q    <= 1'b1;
            lanes_q   <= 4'hF;
            sbg_q     <= 1'b0;
            sterm_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            br_n_q    <= 1'b1;
            fcs_n_q   <= 1'b1;
            ds_n_q    <= 4'hF;
            doe_q     <= 1'b0;
            zread_q   <= 1'b1;
            master_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            read_q    <= read_d;
            lanes_q   <= lanes_d;
            sbg_q     <= sbg_d;
            sterm_n_q <= sterm_n_d;
            berr_n_q  <= berr_n_d;
            br_n_q    <= br_n_d;
            fcs_n_q   <= fcs_n_d;
            ds_n_q    <= ds_n_d;
            doe_q     <= doe_d;
            zread_q   <= zread_d;
            master_q  <= master_d;
        end
    end

    assign SBG       = sbg_q;
    assign S_STERM_n = sterm_n_q;
    assign S_BERR_n  = berr_n_q;
    assign Z_BR_n    = br_n_q;
    assign Z_FCS_n   = fcs_n_q;
    assign Z_DS_n    = ds_n_q;
    assign Z_DOE     = doe_q;
    assign Z_READ    = zread_q;
    assign MASTER    = master_q;

endmodule

// File: doc/z3_master_cycle.md
Z3_MASTER_CYCLE -- requirements
Module: z3_master_cycle

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the cycles from FCS assertion to bus-error abort.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for Zorro inputs.
REQ-003 The port list SHALL be exactly as follows, one port per line: name, direction, width, meaning.
  CLK  in  1  sole clock, the board bus clock.
  RESET  in  1  asynchronous, active-high reset.
  SBR  in  1  NCR bus request, active-high.
  SBG  out  1  grant to NCR, active-high.
  S_AS_n  in  1  NCR address strobe.
  S_READ  in  1  NCR direction, 1 = read.
  S_SIZ  in  2  NCR transfer size; 00 = long.
  S_A  in  2  NCR address bits [1:0].
  S_STERM_n  out  1  synchronous termination to NCR.
  S_BERR_n  out  1  bus error to NCR.
  Z_BR_n  out  1  Zorro bus request.
  Z_BG_n  in  1  Zorro bus grant.
  Z_DTACK_n  in  1  Zorro slave acknowledge.
  Z_BERR_n  in  1  Zorro bus error.
  Z_FCS_n  out  1  Zorro full cycle strobe.
  Z_DS_n  out  4  data strobes; [3] = D31:24.
  Z_DOE  out  1  data output enable.
  Z_READ  out  1  Zorro direction.
  MASTER  out  1  high while the board owns the bus; steers the address/data buffers.

Function
REQ-004 States SHALL be IDLE, ARB, GRANT, ADDR, DATA, TERM, RELEASE, ERROR.
REQ-005 IDLE: SBR=1 -> ARB and assert Z_BR_n.
REQ-006 ARB: synchronized Z_BG_n=0 -> GRANT, assert MASTER and SBG.
REQ-007 ARB: SBR=0 -> IDLE and negate Z_BR_n.
REQ-008 GRANT: S_AS_n=0 -> ADDR; latch S_READ, S_SIZ, S_A; assert Z_FCS_n.
REQ-009 GRANT: SBR=0 with S_AS_n=1 -> IDLE; negate SBG, MASTER and Z_BR_n in the same edge.
REQ-010 ADDR lasts exactly 1 cycle, then DATA.
REQ-011 DATA: assert Z_DOE and the Z_DS_n lanes from REQ-012; Z_READ = latched S_READ from ADDR onward.
REQ-012 Lane decode: n = (SIZ==00) ? 4 : SIZ; lane k (0 = D31:24) is active when A <= k < A+n and k <= 3; Z_DS_n[3-k] = 0.
REQ-013 Lane decode example: A=3 with SIZ=00 SHALL enable lane 3 only.
REQ-014 DATA: synchronized Z_DTACK_n=0 -> TERM.
REQ-015 TERM: S_STERM_n=0 for exactly 1 cycle; negate Z_DS_n and Z_DOE; then RELEASE.
REQ-016 RELEASE: negate Z_FCS_n, then wait for synchronized Z_DTACK_n=1, then GRANT.
REQ-017 Bus ownership SHALL be retained in GRANT for back-to-back NCR cycles.
REQ-018 Timeout counter: 8 bits; cleared in GRANT; increments in ADDR/DATA.
REQ-019 Count == TIMEOUT_CYCLES, or synchronized Z_BERR_n=0, in ADDR/DATA -> ERROR.
REQ-020 ERROR: S_BERR_n=0 for 1 cycle; negate strobes and Z_DOE; then RELEASE.
REQ-021 DTACK and BERR arriving in the same cycle: BERR wins.
REQ-022 Timeout and DTACK arriving in the same cycle: DTACK wins.
REQ-023 Z_BG_n negated while in ADDR or DATA SHALL be ignored until the cycle completes.
REQ-024 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-025 RESET=1 SHALL immediately force state IDLE, counter 0.
REQ-026 RESET=1 SHALL immediately force all *_n outputs high, SBG=0, Z_DOE=0, Z_READ=1, MASTER=0.
REQ-027 Synchronizers SHALL reset to the negated level; reset mid-cycle SHALL abandon the cycle without pulsing S_STERM_n.

Structure
REQ-028 State encoding and the TIMEOUT_CYCLES default SHALL reside in the shared global parameters include.
REQ-029 One sub-module, z3_sync, SHALL be the SYNC_STAGES-deep synchronizer, instanced for Z_BG_n, Z_DTACK_n and Z_BERR_n.

Verification
REQ-030 Read: SBR=1, BG granted, long read at A=0 -> Z_DS_n=0000, Z_READ=1, single S_STERM_n pulse after DTACK plus 2 sync cycles.
REQ-031 Byte write: S_SIZ=01, S_A=2 -> Z_DS_n=1101, Z_DOE=1 in DATA, Z_READ=0.
REQ-032 Back-to-back: two cycles while SBR held -> one Z_BR_n assertion and MASTER held high throughout.
REQ-033 Timeout: DTACK never asserted -> S_BERR_n pulse exactly TIMEOUT_CYCLES+1 cycles after FCS assertion, FCS negated, returns to GRANT.
REQ-034 Reset in DATA: RESET pulse -> all outputs at reset values within the same cycle, no S_STERM_n pulse.
REQ-035 DTACK and BERR in the same cycle -> S_BERR_n pulse, S_STERM_n stays high.
